// File: rtl/tetris_input_ctrl.sv
// rtl/tetris_input_ctrl.sv - joystick direction FSM and debounced buttons for the tetris game
// Optional: define ADC_AVG_EN to threshold the mean of the last four joystick samples.
module tetris_input_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [11:0] ADC_LEFT_TH     = 12'd1000,
    parameter logic [11:0] ADC_RIGHT_TH    = 12'd3000,
    parameter logic [11:0] ADC_HYST        = 12'd200,
    parameter int          CONFIRM         = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] adc_value,
    input  logic        adc_valid,
    input  logic        btn_rotate_n,
    input  logic        btn_drop_n,
    input  logic        game_over,
    output logic        move_left,
    output logic        move_right,
    output logic        move_down,
    output logic        rotate
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam int CW = $clog2(CONFIRM + 1);
    localparam logic [CW-1:0] CONFIRM_N = CW'(CONFIRM);

    localparam logic [12:0] LEFT_TH13  = {1'b0, ADC_LEFT_TH};
    localparam logic [12:0] RIGHT_TH13 = {1'b0, ADC_RIGHT_TH};
    localparam logic [12:0] LEFT_SUM   = {1'b0, ADC_LEFT_TH} + {1'b0, ADC_HYST};
    localparam logic [12:0] LEFT_EXIT  = (LEFT_SUM > 13'd4095) ? 13'd4095 : LEFT_SUM;
    localparam logic [12:0] RIGHT_EXIT = (ADC_RIGHT_TH > ADC_HYST) ?
                                         ({1'b0, ADC_RIGHT_TH} - {1'b0, ADC_HYST}) : 13'd0;

    typedef enum logic [1:0] {CENTER, LEFT, RIGHT} dir_t;

    // bit 0 = rotate, bit 1 = drop; all held as active-low "released = 1"
    logic [1:0]         btn_sync1;
    logic [1:0]         btn_sync2;
    logic [1:0]         btn_acc;
    logic [1:0][DW-1:0] db_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_sync1 <= 2'b11;
            btn_sync2 <= 2'b11;
            btn_acc   <= 2'b11;
            db_cnt    <= '0;
        end else begin
            btn_sync1 <= {btn_drop_n, btn_rotate_n};
            btn_sync2 <= btn_sync1;
            for (int i = 0; i < 2; i++) begin
                if (btn_sync2[i] == btn_acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_acc[i] <= btn_sync2[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [11:0] sample;

`ifdef ADC_AVG_EN
    // hist[0] is the newest previous sample; the current sample joins the mean immediately
    logic [2:0][11:0] hist;
    logic [13:0]      sum;

    assign sum    = {2'b00, adc_value} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
    assign sample = sum[13:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= {3{12'd2048}};
        end else if (adc_valid) begin
            hist <= {hist[1:0], adc_value};
        end
    end
`else
    assign sample = adc_value;
`endif

    dir_t          state, state_next;
    logic [CW-1:0] left_cnt, left_cnt_next;
    logic [CW-1:0] right_cnt, right_cnt_next;
    logic [12:0]   s13;

    assign s13 = {1'b0, sample};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CENTER;
            left_cnt  <= '0;
            right_cnt <= '0;
        end else begin
            state     <= state_next;
            left_cnt  <= left_cnt_next;
            right_cnt <= right_cnt_next;
        end
    end

    // counters are only non-zero while in CENTER, so every entry to CENTER starts from zero
    always_comb begin
        state_next     = state;
        left_cnt_next  = left_cnt;
        right_cnt_next = right_cnt;
        if (game_over) begin
            state_next     = CENTER;
            left_cnt_next  = '0;
            right_cnt_next = '0;
        end else if (adc_valid) begin
            case (state)
                CENTER: begin
                    left_cnt_next  = (s13 < LEFT_TH13)  ? left_cnt + 1'b1  : '0;
                    right_cnt_next = (s13 > RIGHT_TH13) ? right_cnt + 1'b1 : '0;
                    if (left_cnt_next == CONFIRM_N) begin
                        state_next     = LEFT;
                        left_cnt_next  = '0;
                        right_cnt_next = '0;
                    end else if (right_cnt_next == CONFIRM_N) begin
                        state_next     = RIGHT;
                        left_cnt_next  = '0;
                        right_cnt_next = '0;
                    end
                end
                LEFT: begin
                    if (s13 >= LEFT_EXIT) state_next = CENTER;
                end
                RIGHT: begin
                    if (s13 <= RIGHT_EXIT) state_next = CENTER;
                end
                default: begin
                    state_next     = CENTER;
                    left_cnt_next  = '0;
                    right_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            move_left  <= 1'b0;
            move_right <= 1'b0;
            move_down  <= 1'b0;
            rotate     <= 1'b0;
        end else if (game_over) begin
            move_left  <= 1'b0;
            move_right <= 1'b0;
            move_down  <= 1'b0;
            rotate     <= 1'b0;
        end else begin
            move_left  <= (state == LEFT);
            move_right <= (state == RIGHT);
            move_down  <= ~btn_acc[1];
            rotate     <= ~btn_acc[0];
        end
    end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb/tb_tetris_input_ctrl.sv - scoreboard bench for tetris_input_ctrl against a behavioural model
module tb_tetris_input_ctrl;

    localparam int DEB  = 4;
    localparam int CONF = 2;
    localparam int LTH = 1000, RTH = 3000, HYST = 200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] adc_value = 12'd0;
    logic        adc_valid = 1'b0;
    logic        btn_rotate_n = 1'b1;
    logic        btn_drop_n = 1'b1;
    logic        game_over = 1'b0;
    logic        move_left, move_right, move_down, rotate;

    tetris_input_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CONFIRM(CONF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .adc_value(adc_value), .adc_valid(adc_valid),
        .btn_rotate_n(btn_rotate_n), .btn_drop_n(btn_drop_n), .game_over(game_over),
        .move_left(move_left), .move_right(move_right), .move_down(move_down), .rotate(rotate)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit done = 0;
    logic [3:0] exp_q[$];

    // model: {left, right, down, rotate}; direction 0=centre 1=left 2=right
    logic [1:0] m_s1, m_s2, m_acc;
    int m_run[2];
    int m_dir, m_lrun, m_rrun;
    int m_hist[$];
    logic [3:0] m_out;

    function automatic void model_reset();
        m_s1 = 2'b11; m_s2 = 2'b11; m_acc = 2'b11;
        m_run[0] = 0; m_run[1] = 0;
        m_dir = 0; m_lrun = 0; m_rrun = 0;
        m_hist = {2048, 2048, 2048, 2048};
        m_out = 4'b0000;
    endfunction

    function automatic void model_tick();
        logic [3:0] nout;
        int v, sum;
        if (!reset_n) begin
            model_reset();
        end else begin
            nout = game_over ? 4'b0000 :
                   {m_dir == 1, m_dir == 2, ~m_acc[1], ~m_acc[0]};
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_acc[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {btn_drop_n, btn_rotate_n};
            v = int'(adc_value);
`ifdef ADC_AVG_EN
            if (adc_valid) begin
                m_hist.push_back(v);
                void'(m_hist.pop_front());
                sum = 0;
                foreach (m_hist[k]) sum += m_hist[k];
                v = sum / 4;
            end
`else
            sum = 0;
`endif
            if (game_over) begin
                m_dir = 0; m_lrun = 0; m_rrun = 0;
            end else if (adc_valid) begin
                if (m_dir == 0) begin
                    m_lrun = (v < LTH) ? m_lrun + 1 : 0;
                    m_rrun = (v > RTH) ? m_rrun + 1 : 0;
                    if (m_lrun == CONF) begin m_dir = 1; m_lrun = 0; m_rrun = 0; end
                    else if (m_rrun == CONF) begin m_dir = 2; m_lrun = 0; m_rrun = 0; end
                end else if (m_dir == 1) begin
                    if (v >= ((LTH + HYST > 4095) ? 4095 : LTH + HYST)) m_dir = 0;
                end else begin
                    if (v <= ((RTH > HYST) ? RTH - HYST : 0)) m_dir = 0;
                end
            end
            m_out = nout;
        end
        exp_q.push_back(m_out);
    endfunction

    task automatic step();
        model_tick();
        @(posedge clk);
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            adc_valid = 1'b0;
            adc_value = 12'($urandom_range(0, 4095));
            step();
        end
    endtask

    task automatic send(input int v);
        adc_valid = 1'b1;
        adc_value = 12'(v);
        step();
        adc_valid = 1'b0;
        adc_value = 12'($urandom_range(0, 4095));
    endtask

    task automatic check_now(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // monitor: compares every cycle's registered outputs with the queued expectation
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (!done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_underflow: no expectation queued at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check_now("outputs", {move_left, move_right, move_down, rotate}, e);
                    checks++;
                    if (move_left && move_right) begin
                        errors++;
                        $display("FAIL left_right_exclusive: both high at %0t", $time);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        model_reset();
        #1;
        check_now("reset_state", {move_left, move_right, move_down, rotate}, 4'b0000);
        step(); step();
        reset_n = 1'b1;
        idle(7);

        // rotate press: latency from raw edge to output
        btn_rotate_n = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (rotate !== 1'b1 && n < 20);
        check_now("rotate_latency", 4'(n), 4'(2 + DEB + 1));
        idle(5);
        btn_rotate_n = 1'b1;
        idle(10);

        // short glitch must be ignored
        btn_rotate_n = 1'b0;
        idle(3);
        btn_rotate_n = 1'b1;
        idle(10);

        // left entry and hysteresis release
        send(500); idle(1); send(500); idle(2);
        send(1100); idle(2); send(1200); idle(3);

        // right entry with an interrupting sample
        send(3500); send(2000); send(3500); idle(2);
        send(3500); send(3500); idle(2);
        send(2800); idle(3);

        // game over with RIGHT and drop held
        send(3500); send(3500);
        btn_drop_n = 1'b0;
        idle(10);
        game_over = 1'b1;
        step();
        send(4000); send(4000); send(4000);
        game_over = 1'b0;
        idle(4);

        // reset mid-confirm
        send(500); idle(1);
        reset_n = 1'b0;
        #1;
        check_now("async_reset", {move_left, move_right, move_down, rotate}, 4'b0000);
        step(); step();
        reset_n = 1'b1;
        send(500); idle(3);
        check_now("single_sample_after_reset", {3'b000, move_left}, 4'b0000);
        btn_drop_n = 1'b1;
        idle(10);

`ifdef ADC_AVG_EN
        send(0); send(0); idle(2);
        send(0); send(0); idle(3);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: adc_value = 12'($urandom_range(0, 4095));
                1: adc_value = 12'($urandom_range(0, 1300));
                2: adc_value = 12'($urandom_range(2700, 4095));
                default: adc_value = 12'($urandom_range(LTH - 2, LTH + HYST + 2));
            endcase
            adc_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) btn_rotate_n = ~btn_rotate_n;
            if ($urandom_range(0, 9) == 0) btn_drop_n = ~btn_drop_n;
            if ($urandom_range(0, 39) == 0) game_over = ~game_over;
            reset_n = ($urandom_range(0, 499) != 0);
            step();
        end
        reset_n = 1'b1;
        game_over = 1'b0;
        idle(5);

        done = 1;
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d expectations unconsumed, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
